// File: rtl/countdown_seq_ctrl.sv
// Prescaled down-counter timer controller: load, step, terminal count, and
// either stop (one-shot) or reload (auto-reload).
module countdown_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          count_d = '0;
          if (start) begin
            reload_d = load_val;
            mode_d   = auto_reload;
            presc_d  = '0;
            // A zero one-shot load has nothing to count: finish immediately.
            if (load_val == '0 && !auto_reload) begin
              state_d = S_DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = S_RUN;
              count_d = load_val;
            end
          end
        end

        S_RUN: begin
          if (!hold) begin
            if (presc_q == PS_LAST) begin
              presc_d = '0;
              if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
              end else if (count_q == WIDTH'(1)) begin
                count_d = '0;
                tc_d    = 1'b1;
                if (!mode_q) state_d = S_DONE;
              end else begin
                // Only reachable in auto-reload; a zero reload pulses tc every step.
                count_d = reload_q;
                if (reload_q == '0) tc_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign tc    = tc_q;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Directed bench: PRESCALE=1 instance (a) and PRESCALE=3 instance (b) share stimulus.
module tb_countdown_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, hold, auto_reload;
  logic [3:0] load_val;
  logic [3:0] a_count, b_count;
  logic       a_busy, a_done, a_tc, b_busy, b_done, b_tc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(a_count), .busy(a_busy), .done(a_done), .tc(a_tc)
  );

  countdown_seq_ctrl #(.WIDTH(4), .PRESCALE(3)) u_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(b_count), .busy(b_busy), .done(b_done), .tc(b_tc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input int b, input int d, input int t);
    chk({tag, ".count"}, a_count, c);
    chk({tag, ".busy"},  a_busy,  b);
    chk({tag, ".done"},  a_done,  d);
    chk({tag, ".tc"},    a_tc,    t);
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    int exp_c;
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    auto_reload = 1'b0; load_val = 4'd0;
    tick(); tick();
    chk_a("reset_a", 0, 0, 0, 0);
    chk("reset_b.count", b_count, 0);
    chk("reset_b.busy", b_busy, 0);
    reset = 1'b0;
    tick();
    chk_a("idle", 0, 0, 0, 0);

    // One-shot, load 5
    start = 1'b1; load_val = 4'd5; auto_reload = 1'b0;
    tick(); start = 1'b0;
    chk_a("os5_load", 5, 1, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk_a($sformatf("os5_%0d", i), i, (i != 0), (i == 0), (i == 0));
    end
    tick();
    chk_a("os5_after", 0, 0, 1, 0);
    do_abort();
    chk_a("abort_done", 0, 0, 0, 0);
    chk("abort_b.busy", b_busy, 0);

    // Auto-reload, load 15; a start mid-run must be ignored
    start = 1'b1; load_val = 4'd15; auto_reload = 1'b1;
    tick(); start = 1'b0; auto_reload = 1'b0; load_val = 4'd2;
    exp_c = 15;
    chk_a("ar_load", 15, 1, 0, 0);
    for (int j = 1; j <= 40; j++) begin
      start = (j == 20); load_val = 4'd3;
      tick();
      exp_c = (exp_c == 0) ? 15 : exp_c - 1;
      chk_a($sformatf("ar_%0d", j), exp_c, 1, 0, (exp_c == 0));
    end
    start = 1'b0;
    do_abort();
    chk_a("ar_abort", 0, 0, 0, 0);

    // PRESCALE=3 one-shot, load 2
    start = 1'b1; load_val = 4'd2; auto_reload = 1'b0;
    tick(); start = 1'b0;
    chk("p3_load.count", b_count, 2);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("p3_%0d.count", j), b_count, (j < 3) ? 2 : (j < 6) ? 1 : 0);
      chk($sformatf("p3_%0d.tc", j), b_tc, (j == 6));
      chk($sformatf("p3_%0d.done", j), b_done, (j >= 6));
    end
    do_abort();

    // Same run with hold high for 4 cycles: tc moves from 6 to 10
    start = 1'b1; load_val = 4'd2;
    tick(); start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      hold = (j >= 2 && j <= 5);
      tick();
      chk($sformatf("p3h_%0d.count", j), b_count, (j <= 6) ? 2 : (j <= 9) ? 1 : 0);
      chk($sformatf("p3h_%0d.tc", j), b_tc, (j == 10));
    end
    hold = 1'b0;
    do_abort();

    // load_val=0 one-shot: straight to DONE with tc
    start = 1'b1; load_val = 4'd0; auto_reload = 1'b0;
    tick(); start = 1'b0;
    chk_a("z_os", 0, 0, 1, 1);
    tick();
    chk_a("z_os_next", 0, 0, 1, 0);

    // load_val=0 auto-reload on PRESCALE=3: tc every 3 cycles
    start = 1'b1; load_val = 4'd0; auto_reload = 1'b1;
    tick(); start = 1'b0; auto_reload = 1'b0;
    chk("z_ar_load.busy", b_busy, 1);
    chk("z_ar_load.tc", b_tc, 0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk($sformatf("z_ar_%0d.tc", j), b_tc, (j % 3 == 0));
      chk($sformatf("z_ar_%0d.count", j), b_count, 0);
    end
    do_abort();

    // start together with abort: abort wins
    start = 1'b1; load_val = 4'd4;
    tick();
    chk_a("sa_run", 4, 1, 0, 0);
    abort = 1'b1; load_val = 4'd9;
    tick(); start = 1'b0; abort = 1'b0;
    chk_a("sa_abort", 0, 0, 0, 0);

    // Restart from DONE with load 3
    start = 1'b1; load_val = 4'd0;
    tick();
    chk_a("d_enter", 0, 0, 1, 1);
    load_val = 4'd3;
    tick(); start = 1'b0;
    chk_a("d_restart", 3, 1, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk_a($sformatf("d_%0d", i), i, (i != 0), (i == 0), (i == 0));
    end

    // Reset mid-run at count 7, then quiet until start
    start = 1'b1; load_val = 4'd9;
    tick(); start = 1'b0;
    tick(); tick();
    chk("rst_pre.count", a_count, 7);
    reset = 1'b1;
    tick();
    chk_a("rst_mid", 0, 0, 0, 0);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      load_val = 4'(j + 5); auto_reload = j[0];
      tick();
      chk_a($sformatf("rst_quiet_%0d", j), 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
